// File: rtl/imm_extend_unit_pkg.sv
// Shared types and width helpers for the immediate extension unit.
package imm_extend_unit_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int DEF_IN_W    = 3;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_MAX_PFX = 2;

    // Width of the fully assembled word: every held prefix plus the final chunk.
    function automatic int asm_width(input int in_w, input int max_pfx);
        return in_w * (max_pfx + 1);
    endfunction

endpackage

// File: rtl/imm_extend_unit_ext_core.sv
// Combinational extend/truncate of an assembled immediate whose live width is
// asm_len chunks, with overflow detection when it does not fit OUT_W.
module ext_core
    import imm_extend_unit_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int MAX_PFX = DEF_MAX_PFX,
    localparam int ASM_W  = asm_width(IN_W, MAX_PFX),
    localparam int LEN_W  = $clog2(MAX_PFX + 2)
) (
    input  logic [ASM_W-1:0] asm_word,
    input  logic [LEN_W-1:0] asm_len,
    input  logic             is_signed,
    output logic [OUT_W-1:0] ext_data,
    output logic             ext_ovf
);

    localparam int EXT_W = (ASM_W > OUT_W) ? ASM_W : OUT_W;

    logic [EXT_W-1:0] ext;
    logic             fill;
    int               asm_bits;

    // Everything above the live width is replaced by the fill bit.
    always_comb begin
        asm_bits = IN_W * int'(asm_len);
        fill     = 1'b0;
        for (int i = 0; i < ASM_W; i++) begin
            if (i == asm_bits - 1) begin
                fill = is_signed & asm_word[i];
            end
        end
        ext = EXT_W'(asm_word);
        for (int i = 0; i < EXT_W; i++) begin
            if (i >= asm_bits) begin
                ext[i] = fill;
            end
        end
    end

    always_comb begin
        ext_ovf = 1'b0;
        for (int i = OUT_W; i < EXT_W; i++) begin
            if (is_signed) begin
                if (ext[i] != ext[OUT_W-1]) begin
                    ext_ovf = 1'b1;
                end
            end else if (ext[i]) begin
                ext_ovf = 1'b1;
            end
        end
    end

    assign ext_data = ext[OUT_W-1:0];

endmodule

// File: rtl/imm_extend_unit.sv
// Assembles prefix chunks and a final chunk into one immediate, then registers
// the sign- or zero-extended result behind a valid/ready output.
module imm_extend_unit
    import imm_extend_unit_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int MAX_PFX = DEF_MAX_PFX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_field,
    input  logic            in_prefix,
    input  logic            in_signed,
    input  logic            in_flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic            out_ovf
);

    localparam int ASM_W = asm_width(IN_W, MAX_PFX);
    localparam int PFX_W = IN_W * MAX_PFX;
    localparam int CNT_W = $clog2(MAX_PFX + 1);
    localparam int LEN_W = $clog2(MAX_PFX + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PFX);

    state_t           state, state_n;
    logic [PFX_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lost, lost_n;
    logic             in_xfer, take_pfx, take_final;
    logic [LEN_W-1:0] asm_len;
    logic [OUT_W-1:0] core_data;
    logic             core_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            lost      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            lost  <= lost_n;
            if (take_final) begin
                out_valid <= 1'b1;
                out_data  <= core_data;
                out_ovf   <= core_ovf | lost;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A flush swallows whatever chunk is transferred alongside it.
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cnt_n      = cnt;
        lost_n     = lost;
        in_xfer    = in_valid && in_ready;
        take_pfx   = in_xfer && in_prefix && !in_flush;
        take_final = in_xfer && !in_prefix && !in_flush;
        if (in_flush || take_final) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            lost_n  = 1'b0;
        end else if (take_pfx) begin
            state_n = ACCUM;
            acc_n   = (acc << IN_W) | PFX_W'(in_field);
            if (cnt == CNT_MAX) begin
                lost_n = 1'b1;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        in_ready = !out_valid || out_ready;
        asm_len  = (state == IDLE) ? LEN_W'(1) : LEN_W'(cnt) + LEN_W'(1);
    end

    ext_core #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .MAX_PFX (MAX_PFX)
    ) u_ext_core (
        .asm_word  ({acc, in_field}),
        .asm_len   (asm_len),
        .is_signed (in_signed),
        .ext_data  (core_data),
        .ext_ovf   (core_ovf)
    );

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed cases plus a randomized
// run against a chunk-queue reference model.
module tb_imm_extend_unit;

    localparam int IN_W    = 3;
    localparam int OUT_W   = 8;
    localparam int MAX_PFX = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [2:0] in_field;
    logic       in_prefix, in_signed, in_flush;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    int         pfx_q[$];
    bit         lost_m;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_ovf;

    always #5 clk = ~clk;

    imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .MAX_PFX(MAX_PFX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_field  (in_field),
        .in_prefix (in_prefix),
        .in_signed (in_signed),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // Reference: chunks kept as integers, result computed as a numeric value.
    function automatic void model_prefix(input logic [2:0] f);
        pfx_q.push_back(int'(f));
        if (pfx_q.size() > MAX_PFX) begin
            void'(pfx_q.pop_front());
            lost_m = 1'b1;
        end
    endfunction

    function automatic void model_final(input logic [2:0] f, input bit sgn,
                                        output logic [7:0] d, output bit ovf);
        longint val;
        int     bits;
        val = 0;
        foreach (pfx_q[i]) val = (val << IN_W) | longint'(pfx_q[i]);
        val  = (val << IN_W) | longint'(f);
        bits = IN_W * (pfx_q.size() + 1);
        if (sgn && val >= (longint'(1) << (bits - 1))) val = val - (longint'(1) << bits);
        d   = val[7:0];
        ovf = lost_m || (sgn ? (val < -128 || val > 127) : (val > 255));
        pfx_q.delete();
        lost_m = 1'b0;
    endfunction

    task automatic applyStimulus(input logic v, input logic [2:0] f, input logic p,
                                 input logic s, input logic fl, input logic ordy);
        in_valid  = v;
        in_field  = f;
        in_prefix = p;
        in_signed = s;
        in_flush  = fl;
        out_ready = ordy;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
        stepClock();
        stepClock();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h o=%b expected v=0 d=00 o=0", out_valid, out_data, out_ovf);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        stepClock();
    endtask

    task automatic test_single_chunk();
        applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h05 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_unsigned: got v=%b d=%h o=%b expected v=1 d=05 o=0", out_valid, out_data, out_ovf);
        end
        applyStimulus(1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready);
        end
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFD || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_signed: got v=%b d=%h o=%b expected v=1 d=FD o=0", out_valid, out_data, out_ovf);
        end
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_two_chunk();
        applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h1E || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_chunk_pos: got v=%b d=%h o=%b expected v=1 d=1E o=0", out_valid, out_data, out_ovf);
        end
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hF8 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_chunk_neg: got v=%b d=%h o=%b expected v=1 d=F8 o=0", out_valid, out_data, out_ovf);
        end
    endtask

    task automatic test_overflow();
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
            stepClock();
            applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
            stepClock();
            applyStimulus(1'b1, 3'b100, 1'b0, s[0], 1'b0, 1'b1);
            stepClock();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h8C || out_ovf !== s[0]) begin
                errors++;
                $display("[TB] FAIL three_chunk_s%0d: got v=%b d=%h o=%b expected v=1 d=8C o=%0d", s, out_valid, out_data, out_ovf, s);
            end
        end
        applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h98 || out_ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lost_prefix: got v=%b d=%h o=%b expected v=1 d=98 o=1", out_valid, out_data, out_ovf);
        end
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
    endtask

    task automatic test_backpressure();
        applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_in_ready_%0d: got %b expected 0", i, in_ready);
            end
            stepClock();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h05 || out_ovf !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got v=%b d=%h o=%b expected v=1 d=05 o=0", i, out_valid, out_data, out_ovf);
            end
        end
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: got %b expected 0", out_valid);
        end
        applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h02 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_ignored_chunks: got v=%b d=%h o=%b expected v=1 d=02 o=0", out_valid, out_data, out_ovf);
        end
    endtask

    task automatic test_flush_reset();
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        rst = 1'b0;
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset: got v=%b d=%h o=%b expected v=1 d=01 o=0", out_valid, out_data, out_ovf);
        end
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_flush: got v=%b d=%h o=%b expected v=1 d=01 o=0", out_valid, out_data, out_ovf);
        end
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        stepClock();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h06 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_keeps_output: got v=%b d=%h o=%b expected v=1 d=06 o=0", out_valid, out_data, out_ovf);
        end
        applyStimulus(1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1);
        stepClock();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_drops_final: got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_random();
        logic       v, p, s, fl, ordy;
        logic [2:0] f;
        bit         exp_ready, xfer;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        stepClock();
        pfx_q.delete();
        lost_m    = 1'b0;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_ovf   = 1'b0;
        for (int n = 0; n < 300; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            f    = 3'($urandom);
            p    = 1'($urandom_range(0, 1));
            s    = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 11) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            applyStimulus(v, f, p, s, fl, ordy);
            #1;
            exp_ready = !exp_valid || ordy;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, exp_ready);
            end
            xfer = v && exp_ready;
            if (exp_valid && ordy) exp_valid = 1'b0;
            if (fl) begin
                pfx_q.delete();
                lost_m = 1'b0;
            end else if (xfer && p) begin
                model_prefix(f);
            end else if (xfer && !p) begin
                model_final(f, s, exp_data, exp_ovf);
                exp_valid = 1'b1;
            end
            stepClock();
            checks++;
            if (out_valid !== exp_valid) begin
                errors++;
                $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", n, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== exp_data || out_ovf !== exp_ovf) begin
                    errors++;
                    $display("[TB] FAIL rand_result[%0d]: got d=%h o=%b expected d=%h o=%b", n, out_data, out_ovf, exp_data, exp_ovf);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single_chunk();
        test_two_chunk();
        test_overflow();
        test_backpressure();
        test_flush_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
